// File: rtl/data_mem_bus.sv
// Data memory behind a req/ready/done handshake with programmable wait states,
// byte/half/word stores with lane masking, sign/zero-extending loads and error reporting.
module data_mem_bus #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] a,
  input  logic [31:0]       wd,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rd,
  output logic              err
);

  localparam int unsigned     IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DepthA = ADDR_W'(DEPTH);
  localparam logic [3:0]      WaitLoad = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam bit              NoWait   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [31:0]       wd_q;
  logic [31:0]       rd_q;
  logic              err_q;

  logic [31:0] mem [DEPTH];

  logic              idle;
  logic [ADDR_W-1:0] cur_a;
  logic              cur_we, cur_uns;
  logic [1:0]        cur_size;
  logic [31:0]       cur_wd;
  logic              acc_err;
  logic              accept;
  logic              enter_resp;
  logic              wr_en;
  logic [IdxW-1:0]   idx;
  logic [31:0]       word_rd;
  logic [31:0]       shifted;
  logic [31:0]       ext;
  logic [3:0]        be;
  logic [31:0]       wlanes;

  // The access resolved on the RESP-entry edge comes straight from the inputs when no
  // wait state is taken, otherwise from the values latched at accept.
  assign idle     = (state_q == StIdle);
  assign cur_a    = idle ? a    : a_q;
  assign cur_we   = idle ? we   : we_q;
  assign cur_uns  = idle ? uns  : uns_q;
  assign cur_size = idle ? size : size_q;
  assign cur_wd   = idle ? wd   : wd_q;

  assign idx     = cur_a[IdxW+1:2];
  assign word_rd = mem[idx];

  always_comb begin
    acc_err = 1'b0;
    case (cur_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = cur_a[0];
      2'b10:   acc_err = |cur_a[1:0];
      default: acc_err = 1'b1;
    endcase
    if ({2'b00, cur_a[ADDR_W-1:2]} >= DepthA) acc_err = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          accept = 1'b1;
          if (acc_err || NoWait) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shifted = word_rd >> {cur_a[1:0], 3'b000};
    case (cur_size)
      2'b00:   ext = {{24{~cur_uns & shifted[7]}}, shifted[7:0]};
      2'b01:   ext = {{16{~cur_uns & shifted[15]}}, shifted[15:0]};
      default: ext = word_rd;
    endcase
  end

  always_comb begin
    be     = 4'b0000;
    wlanes = cur_wd;
    case (cur_size)
      2'b00: begin
        be     = 4'b0001 << cur_a[1:0];
        wlanes = {4{cur_wd[7:0]}};
      end
      2'b01: begin
        be     = cur_a[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{cur_wd[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Storage has no reset; gating with rst_n drops a store whose commit edge meets reset.
  assign wr_en = enter_resp & ~acc_err & cur_we & rst_n;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      a_q     <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q    <= a;
        we_q   <= we;
        size_q <= size;
        uns_q  <= uns;
        wd_q   <= wd;
      end
      if (enter_resp) begin
        err_q <= acc_err;
        rd_q  <= (acc_err || cur_we) ? 32'd0 : ext;
      end
    end
  end

  assign ready = (state_q == StIdle);
  assign done  = (state_q == StResp);
  assign rd    = rd_q;
  assign err   = err_q;

endmodule
